pong_rally_controller: RTL and testbench

Parametrised successor to the single-player Controller FSM. It runs a complete two-player Pong rally on an N-LED bar. Internal step timing replaces the external T5/T20 timers, and the speed level rises with the rally hit count. The block sits between the debounced/synchronised button inputs and the LED/score display logic at the top level.

---
 rtl/pong_pkg.sv | 23 ++
 rtl/pong_step_timer.sv | 33 +++
 rtl/pong_rally_controller.sv | 199 +++++++++++++++++++
 tb/tb_pong_rally_controller.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the pong rally controller.
//   - FSM state codes (exposed on the controller's 'state' output)
//   - player identifiers used for server / scorer / winner
//   - step_period(): cycles per ball step at a given speed level
package pong_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SERVE    = 3'd1;
  localparam logic [2:0] ST_MOVE_R   = 3'd2;
  localparam logic [2:0] ST_MOVE_L   = 3'd3;
  localparam logic [2:0] ST_POINT    = 3'd4;
  localparam logic [2:0] ST_GAMEOVER = 3'd5;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  // Each level halves the step period.
  function automatic int unsigned step_period(input int unsigned base,
                                              input int unsigned lvl);
    return base >> lvl;
  endfunction

endpackage

// File: rtl/pong_step_timer.sv
// Loadable down-counter that paces the ball.
//   Clk, Rst  : clock, synchronous active-high reset
//   load      : (re)start the interval; has priority over counting
//   load_val  : interval length in cycles (>= 1)
//   expire    : high in the last cycle of the interval
// A load of value P makes expire rise exactly P cycles later (P-1 for the
// counter, plus the final cycle where count == 0). The count rests at 0
// once expired, so expire stays high until the next load.
module pong_step_timer #(
  parameter int W = 3
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val - W'(1);
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/pong_rally_controller.sv
// Two-player Pong rally controller for an N_LEDS LED bar.
//   Clk, Rst          : clock, synchronous active-high reset
//   start             : start / restart (rising edge, IDLE or GAMEOVER only)
//   p_left, p_right   : paddle buttons (rising edge used)
//   out               : LED bar; bit N_LEDS-1 is the left end
//   score_l, score_r  : player scores, saturate at WIN_SCORE
//   level             : speed level, rises every HITS_PER_LEVEL returns
//   state             : FSM state code (pong_pkg ST_*)
//   game_over, winner : match result (winner 0 = left, 1 = right)
// Handshake note: there is no valid/ready traffic here; every input is a
// level whose rising edge is an event, and every output is a function of
// registered state, so an input edge shows up on the outputs one cycle later.
module pong_rally_controller
  import pong_pkg::*;
#(
  parameter int N_LEDS         = 8,
  parameter int BASE_PERIOD    = 4,
  parameter int MAX_LEVEL      = 2,
  parameter int HITS_PER_LEVEL = 2,
  parameter int WIN_SCORE      = 2,
  parameter int SERVE_CYCLES   = 3,
  parameter int POINT_CYCLES   = 2
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic                             start,
  input  logic                             p_left,
  input  logic                             p_right,
  output logic [N_LEDS-1:0]                out,
  output logic [$clog2(WIN_SCORE+1)-1:0]   score_l,
  output logic [$clog2(WIN_SCORE+1)-1:0]   score_r,
  output logic [$clog2(MAX_LEVEL+1)-1:0]   level,
  output logic [2:0]                       state,
  output logic                             game_over,
  output logic                             winner
);

  localparam int SW   = $clog2(WIN_SCORE + 1);
  localparam int LW   = $clog2(MAX_LEVEL + 1);
  localparam int HW   = $clog2(HITS_PER_LEVEL + 1);
  localparam int TW   = $clog2(BASE_PERIOD + 1);
  localparam int PW   = $clog2(N_LEDS);
  localparam int CMAX = (SERVE_CYCLES > POINT_CYCLES) ? SERVE_CYCLES : POINT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [PW-1:0]     LEFT_END = PW'(N_LEDS - 1);
  localparam logic [N_LEDS-1:0] HALF_L   = {{(N_LEDS/2){1'b1}}, {(N_LEDS/2){1'b0}}};
  localparam logic [N_LEDS-1:0] HALF_R   = ~HALF_L;
  localparam logic [N_LEDS-1:0] ONE_LED  = {{(N_LEDS-1){1'b0}}, 1'b1};

  logic [PW-1:0] pos;
  logic          server;
  logic          scorer;
  logic [HW-1:0] hits;
  logic [CW-1:0] cnt;
  logic          start_d, pl_d, pr_d;

  logic          rise_start, rise_l, rise_r;
  logic          moving, recv_rise, at_end;
  logic [PW-1:0] recv_end;
  logic          hit, fault, step;
  logic [HW-1:0] hits_inc;
  logic          level_up;
  logic [LW-1:0] hit_level;
  logic          serve_done;
  logic          timer_load, expire;
  logic [TW-1:0] timer_val;
  logic          scorer_now;
  logic [SW-1:0] scorer_score;

  assign rise_start = start   & ~start_d;
  assign rise_l     = p_left  & ~pl_d;
  assign rise_r     = p_right & ~pr_d;

  // Only the receiving player's button matters while the ball is moving.
  assign moving    = (state == ST_MOVE_R) || (state == ST_MOVE_L);
  assign recv_rise = (state == ST_MOVE_R) ? rise_r : rise_l;
  assign recv_end  = (state == ST_MOVE_R) ? '0 : LEFT_END;
  assign at_end    = (pos == recv_end);

  // A press always takes priority over a simultaneous timer expiry.
  assign hit   = moving & recv_rise & at_end;
  assign fault = moving & ((recv_rise & ~at_end) | (~recv_rise & expire & at_end));
  assign step  = moving & ~recv_rise & expire & ~at_end;

  assign hits_inc  = hits + HW'(1);
  assign level_up  = (hits_inc == HW'(HITS_PER_LEVEL));
  assign hit_level = (level_up && (level != LW'(MAX_LEVEL))) ? level + LW'(1) : level;

  assign serve_done = (state == ST_SERVE) && (cnt == '0);

  // Timer restarts at ball launch, after each step and after each hit
  // (a hit may already have raised the level, so use the new period).
  assign timer_load = serve_done | step | hit;
  assign timer_val  = TW'(step_period(BASE_PERIOD, hit ? 32'(hit_level) : 32'(level)));

  // The player opposite the receiver takes the point.
  assign scorer_now   = (state == ST_MOVE_R) ? LEFT : RIGHT;
  assign scorer_score = (scorer == LEFT) ? score_l : score_r;

  pong_step_timer #(.W(TW)) u_timer (
    .Clk      (Clk),
    .Rst      (Rst),
    .load     (timer_load),
    .load_val (timer_val),
    .expire   (expire)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= ST_IDLE;
      pos     <= '0;
      server  <= LEFT;
      scorer  <= LEFT;
      winner  <= LEFT;
      score_l <= '0;
      score_r <= '0;
      level   <= '0;
      hits    <= '0;
      cnt     <= '0;
      start_d <= 1'b0;
      pl_d    <= 1'b0;
      pr_d    <= 1'b0;
    end else begin
      start_d <= start;
      pl_d    <= p_left;
      pr_d    <= p_right;
      case (state)
        ST_IDLE, ST_GAMEOVER: begin
          if (rise_start) begin
            score_l <= '0;
            score_r <= '0;
            level   <= '0;
            hits    <= '0;
            server  <= LEFT;
            pos     <= LEFT_END;
            cnt     <= CW'(SERVE_CYCLES - 1);
            state   <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (cnt == '0) begin
            state <= (server == LEFT) ? ST_MOVE_R : ST_MOVE_L;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_MOVE_R, ST_MOVE_L: begin
          if (hit) begin
            state <= (state == ST_MOVE_R) ? ST_MOVE_L : ST_MOVE_R;
            hits  <= level_up ? '0 : hits_inc;
            level <= hit_level;
          end else if (fault) begin
            scorer <= scorer_now;
            if (scorer_now == LEFT) begin
              if (score_l != SW'(WIN_SCORE)) score_l <= score_l + SW'(1);
            end else begin
              if (score_r != SW'(WIN_SCORE)) score_r <= score_r + SW'(1);
            end
            level <= '0;
            hits  <= '0;
            cnt   <= CW'(POINT_CYCLES - 1);
            state <= ST_POINT;
          end else if (step) begin
            pos <= (state == ST_MOVE_R) ? pos - PW'(1) : pos + PW'(1);
          end
        end
        ST_POINT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (scorer_score == SW'(WIN_SCORE)) begin
            winner <= scorer;
            state  <= ST_GAMEOVER;
          end else begin
            // The player who lost the point serves from their own end.
            server <= ~scorer;
            pos    <= (scorer == LEFT) ? '0 : LEFT_END;
            cnt    <= CW'(SERVE_CYCLES - 1);
            state  <= ST_SERVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    out = '0;
    case (state)
      ST_SERVE, ST_MOVE_R, ST_MOVE_L: out = ONE_LED << pos;
      ST_POINT:                       out = (scorer == LEFT) ? HALF_L : HALF_R;
      ST_GAMEOVER:                    out = (winner == LEFT) ? HALF_L : HALF_R;
      default:                        out = '0;
    endcase
  end

  assign game_over = (state == ST_GAMEOVER);

endmodule

// File: tb/tb_pong_rally_controller.sv
module tb_pong_rally_controller;

  localparam int N    = 8;
  localparam int BASE = 4;
  localparam int MAXL = 2;
  localparam int HPL  = 2;
  localparam int WIN  = 2;
  localparam int SRV  = 3;
  localparam int PNT  = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst, start, p_left, p_right;
  logic [7:0] out;
  logic [1:0] score_l, score_r, level;
  logic [2:0] state;
  logic       game_over, winner;

  always #5 clk = ~clk;

  pong_rally_controller dut (
    .Clk       (clk),
    .Rst       (rst),
    .start     (start),
    .p_left    (p_left),
    .p_right   (p_right),
    .out       (out),
    .score_l   (score_l),
    .score_r   (score_r),
    .level     (level),
    .state     (state),
    .game_over (game_over),
    .winner    (winner)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Game described as phases with "cycles remaining" counters.
  bit m_valid = 0;
  int m_phase, m_ball, m_server, m_sl, m_sr, m_level, m_hits;
  int m_scorer, m_winner, m_left_cycles, m_remaining;
  bit ps, pl, pr;

  task automatic award(input int who);
    m_scorer = who;
    if (who == 0) m_sl = (m_sl < WIN) ? m_sl + 1 : m_sl;
    else          m_sr = (m_sr < WIN) ? m_sr + 1 : m_sr;
    m_level = 0;
    m_hits  = 0;
    m_phase = 4;
    m_remaining = PNT;
  endtask

  task automatic new_game();
    m_sl = 0; m_sr = 0; m_level = 0; m_hits = 0;
    m_server = 0; m_ball = N - 1; m_phase = 1; m_remaining = SRV;
  endtask

  always @(posedge clk) begin
    bit rs, rl, rr, going_right, recv;
    int dest;
    if (rst) begin
      m_valid = 1;
      m_phase = 0; m_ball = 0; m_server = 0; m_sl = 0; m_sr = 0;
      m_level = 0; m_hits = 0; m_scorer = 0; m_winner = 0;
      m_left_cycles = 0; m_remaining = 0;
      ps = 0; pl = 0; pr = 0;
    end else if (m_valid) begin
      rs = start && !ps;
      rl = p_left && !pl;
      rr = p_right && !pr;
      ps = start; pl = p_left; pr = p_right;
      case (m_phase)
        0, 5: if (rs) new_game();
        1: begin
          m_remaining--;
          if (m_remaining == 0) begin
            m_phase = (m_server == 0) ? 2 : 3;
            m_left_cycles = BASE >> m_level;
          end
        end
        2, 3: begin
          going_right = (m_phase == 2);
          recv = going_right ? rr : rl;
          dest = going_right ? 0 : N - 1;
          if (recv) begin
            if (m_ball == dest) begin
              m_hits++;
              if (m_hits == HPL) begin
                m_hits = 0;
                if (m_level < MAXL) m_level++;
              end
              m_phase = going_right ? 3 : 2;
              m_left_cycles = BASE >> m_level;
            end else begin
              award(going_right ? 0 : 1);
            end
          end else begin
            m_left_cycles--;
            if (m_left_cycles == 0) begin
              if (m_ball == dest) award(going_right ? 0 : 1);
              else begin
                m_ball += going_right ? -1 : 1;
                m_left_cycles = BASE >> m_level;
              end
            end
          end
        end
        4: begin
          m_remaining--;
          if (m_remaining == 0) begin
            if ((m_scorer == 0 ? m_sl : m_sr) == WIN) begin
              m_winner = m_scorer;
              m_phase = 5;
            end else begin
              m_server = 1 - m_scorer;
              m_ball = (m_server == 0) ? N - 1 : 0;
              m_phase = 1;
              m_remaining = SRV;
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  function automatic logic [7:0] exp_out();
    case (m_phase)
      1, 2, 3: return 8'(1 << m_ball);
      4:       return (m_scorer == 0) ? 8'hF0 : 8'h0F;
      5:       return (m_winner == 0) ? 8'hF0 : 8'h0F;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("out",       32'(out),       32'(exp_out()));
      chk("state",     32'(state),     32'(m_phase));
      chk("score_l",   32'(score_l),   32'(m_sl));
      chk("score_r",   32'(score_r),   32'(m_sr));
      chk("level",     32'(level),     32'(m_level));
      chk("game_over", 32'(game_over), 32'(m_phase == 5));
      if (m_phase == 5) chk("winner", 32'(winner), 32'(m_winner));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_l();
    p_left = 1'b1; @(negedge clk); p_left = 1'b0;
  endtask

  task automatic press_r();
    p_right = 1'b1; @(negedge clk); p_right = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_out(input logic [7:0] v, input string name);
    int k = 0;
    while (out !== v && k < 60) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (out !== v) begin
      n_err++;
      $display("FAIL wait_%s: got %0h expected %0h (timeout)", name, out, v);
    end
  endtask

  // ---------------- directed stimulus with pinned literals ----------------
  initial begin
    rst = 1'b1; start = 1'b0; p_left = 1'b0; p_right = 1'b0;
    tick(3);
    chk("rst_out", 32'(out), 32'h00);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_scores", 32'({score_l, score_r}), 32'd0);
    rst = 1'b0;

    // serve and first rally step timing
    pulse_start();
    chk("start_state", 32'(state), 32'd1);
    chk("start_out", 32'(out), 32'h80);
    tick(3);
    chk("launch_state", 32'(state), 32'd2);
    chk("launch_out", 32'(out), 32'h80);
    tick(4);
    chk("step1_out", 32'(out), 32'h40);

    // miss at the right end
    wait_out(8'h01, "miss_end");
    tick(4);
    chk("miss_state", 32'(state), 32'd4);
    chk("miss_score_l", 32'(score_l), 32'd1);
    chk("miss_out", 32'(out), 32'hF0);
    tick(2);
    chk("reserve_state", 32'(state), 32'd1);
    chk("reserve_out", 32'(out), 32'h01);
    tick(3);
    chk("reserve_move", 32'(state), 32'd3);

    // rally and speed-up
    wait_out(8'h80, "hit1"); press_l();
    wait_out(8'h01, "hit2"); press_r();
    chk("level1", 32'(level), 32'd1);
    wait_out(8'h02, "l1_step");
    tick(2);
    chk("l1_period", 32'(out), 32'h04);
    wait_out(8'h80, "hit3"); press_l();
    wait_out(8'h01, "hit4"); press_r();
    chk("level2", 32'(level), 32'd2);
    wait_out(8'h02, "l2_step");
    tick(1);
    chk("l2_period", 32'(out), 32'h04);
    wait_out(8'h80, "hit5"); press_l();

    // held right button: one hit only, no later early fault
    wait_out(8'h01, "hit6");
    p_right = 1'b1;
    tick(5);
    chk("held_state", 32'(state), 32'd3);
    chk("held_out", 32'(out), 32'h10);
    chk("level_sat", 32'(level), 32'd2);
    wait_out(8'h80, "hit7"); press_l();
    wait_out(8'h20, "held_ret");
    chk("held_no_fault", 32'(state), 32'd2);
    p_right = 1'b0;

    // early press -> second point to left -> game over
    wait_out(8'h08, "early");
    press_r();
    chk("early_state", 32'(state), 32'd4);
    chk("early_score_l", 32'(score_l), 32'd2);
    chk("early_level", 32'(level), 32'd0);
    tick(2);
    chk("go_state", 32'(state), 32'd5);
    chk("go_flag", 32'(game_over), 32'd1);
    chk("go_winner", 32'(winner), 32'd0);
    chk("go_out", 32'(out), 32'hF0);
    pulse_start();
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_scores", 32'({score_l, score_r}), 32'd0);
    chk("restart_out", 32'(out), 32'h80);

    // reset in the middle of MOVE_L at level 1
    tick(3);
    wait_out(8'h01, "r_hit1"); press_r();
    wait_out(8'h80, "r_hit2"); press_l();
    wait_out(8'h01, "r_hit3"); press_r();
    tick(2);
    chk("pre_rst_state", 32'(state), 32'd3);
    chk("pre_rst_level", 32'(level), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_out", 32'(out), 32'h00);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_go", 32'(game_over), 32'd0);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
